alarm_controller: RTL
=====================

# alarm_controller

Sequencing and arbitration controller for the three-alarm clock. It chooses which time source the display mux shows. It detects alarm matches on the one-second tick and arbitrates between simultaneous or overlapping alarms. It also runs the ring/snooze/dismiss state machine that drives the buzzer. It sits between the debounced button inputs, the time-keeping counters and the display mux select lines.

## Interface
- RING_SECONDS, 60: ticks an alarm rings before auto-dismiss
- SNOOZE_SECONDS, 300: ticks of snooze before re-ring
- MAX_SNOOZE, 3: snoozes allowed per alarm event; further snooze presses dismiss

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- tick_1hz  in  1  one-cycle pulse per second
- horario_relogio  in  24  current time, BCD hhmmss
- horario_alarme_1/2/3  in  24 each  alarm times, BCD hhmmss
- alarme_en  in  3  per-alarm enable, bit0 = alarm 1
- botao_pause  in  1  dismiss button, level, debounced upstream
- botao_snooze  in  1  snooze button, level, debounced upstream
- botao_modo  in  1  display-cycle button, level, debounced upstream
- sel_relogio, sel_alarme1, sel_alarme2, sel_alarme3  out  1 each  one-hot display mux select
- buzzer  out  1  buzzer drive
- alarme_ativo  out  2  alarm being serviced: 0 none, 1..3
- snoozing  out  1  high in SNOOZE state

## Operation
- Buttons are rising-edge detected internally with one register each. One press is one event.
- Display select:
  - Each botao_modo edge advances RELOGIO -> A1 -> A2 -> A3 -> RELOGIO.
  - While in RINGING, the select is forced to RELOGIO and modo edges are ignored.
  - The select returns to its stored value afterwards.
- Match:
  - Evaluated only on cycles with tick_1hz=1.
  - Alarm i matches when alarme_en[i] is set and horario_relogio == horario_alarme_i.
  - A match sets pending[i].
- Arbitration: the lowest-index pending alarm is serviced first. Other pending flags are held until that service ends.
- FSM states: IDLE, RINGING, SNOOZE.
  - IDLE -> RINGING: when any pending bit is set, or on a match in the current cycle. Loads alarme_ativo, clears ring_cnt and snooze_cnt, clears that alarm's pending bit, sets beep=1.
  - RINGING:
    - buzzer = beep; beep toggles on each tick.
    - ring_cnt increments per tick.
    - ring_cnt == RING_SECONDS-1 with tick -> dismiss.
    - pause edge -> dismiss.
    - snooze edge with snooze_cnt < MAX_SNOOZE -> SNOOZE and snooze_cnt+1.
    - snooze edge with snooze_cnt == MAX_SNOOZE -> dismiss.
  - SNOOZE:
    - buzzer=0, snoozing=1.
    - wait_cnt increments per tick.
    - wait_cnt == SNOOZE_SECONDS-1 with tick -> RINGING, with ring_cnt cleared and beep=1.
    - pause edge -> dismiss.
  - Dismiss: alarme_ativo=0. Go to IDLE, which services the next pending alarm on the following cycle.
- Simultaneous pause and snooze edges: pause wins.
- Clearing alarme_en[i]:
  - Clears pending[i] immediately.
  - If alarm i is being serviced, it is dismissed in the same cycle.
- A match on the alarm being serviced (same time re-hit 24 h later) is ignored.
- Counter widths: ceil(log2) of the largest parameter value. Counters saturate; they never wrap.

## Timing
- Reset values:
  - sel_relogio=1, other selects 0.
  - buzzer=0, alarme_ativo=0, snoozing=0.
  - FSM=IDLE; pending, all counters and beep cleared.
- All outputs are registered.
- Match on a tick in cycle t with FSM in IDLE: buzzer=1 and alarme_ativo valid in cycle t+1.
- Button edge in cycle t (input rises at t): state and output change visible in cycle t+2. This is 1 cycle for the edge register plus 1 for the FSM.
- Display select changes 2 cycles after a botao_modo rise.
- Asserting rst mid-ring forces the buzzer low asynchronously. All pending alarms are lost.

## Test plan
- Set alarm1=07:00:00 with en=001. Count the clock through 07:00:00 on ticks. Expect buzzer=1 and alarme_ativo=1 one cycle after the matching tick. Expect buzzer to toggle each tick and to auto-dismiss after 60 ticks with alarme_ativo=0.
- Set alarm1 = alarm2 = 08:30:00, both enabled. Expect alarm 1 serviced first. After a pause press, expect alarme_ativo=2 and buzzer=1 within 3 cycles.
- While ringing, press snooze 3 times with a 300-tick wait each time. Expect re-ring after each wait. On the 4th snooze press, expect dismiss (alarme_ativo=0, snoozing=0).
- Raise pause and snooze in the same cycle while RINGING. Expect dismiss, not SNOOZE.
- In IDLE, press modo 5 times. Expect the select sequence A1, A2, A3, RELOGIO, A1. A match mid-sequence forces sel_relogio=1 while ringing, and the A1 select is restored after dismiss.
- Assert rst during SNOOZE, and separately clear alarme_en[0] during RINGING. Expect buzzer=0, alarme_ativo=0 and FSM in IDLE in both cases. Expect no re-ring after the snooze interval elapses.

Source files
------------

// File: rtl/alarm_controller.sv
`default_nettype none
// ============================================================================
//  Module   : alarm_controller
//  Purpose  : Three-alarm match/arbitration, ring/snooze/dismiss sequencing
//             and display-mux select for the alarm clock.
//  Revision : 1.0  initial release
// ============================================================================
module alarm_controller #(
    parameter int RING_SECONDS   = 60,
    parameter int SNOOZE_SECONDS = 300,
    parameter int MAX_SNOOZE     = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick_1hz,
    input  logic [23:0] horario_relogio,
    input  logic [23:0] horario_alarme_1,
    input  logic [23:0] horario_alarme_2,
    input  logic [23:0] horario_alarme_3,
    input  logic [2:0]  alarme_en,
    input  logic        botao_pause,
    input  logic        botao_snooze,
    input  logic        botao_modo,
    output logic        sel_relogio,
    output logic        sel_alarme1,
    output logic        sel_alarme2,
    output logic        sel_alarme3,
    output logic        buzzer,
    output logic [1:0]  alarme_ativo,
    output logic        snoozing
);

    localparam int c_max_a = (RING_SECONDS > SNOOZE_SECONDS) ? RING_SECONDS : SNOOZE_SECONDS;
    localparam int c_max_p = (c_max_a > MAX_SNOOZE) ? c_max_a : MAX_SNOOZE;
    localparam int c_cw    = (c_max_p > 1) ? $clog2(c_max_p + 1) : 1;

    localparam logic [c_cw-1:0] c_ring_last   = c_cw'(RING_SECONDS - 1);
    localparam logic [c_cw-1:0] c_snooze_last = c_cw'(SNOOZE_SECONDS - 1);
    localparam logic [c_cw-1:0] c_snooze_max  = c_cw'(MAX_SNOOZE);
    localparam logic [c_cw-1:0] c_one         = c_cw'(1);
    localparam logic [3:0]      c_sel_clock   = 4'b0001;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RINGING = 2'd1,
        S_SNOOZE  = 2'd2
    } state_t;

    state_t            r_state;
    logic [2:0]        r_btn_q;
    logic [2:0]        r_btn_evt;
    logic [2:0]        r_pending;
    logic [1:0]        r_disp;
    logic [3:0]        r_sel;
    logic [1:0]        r_active;
    logic              r_buzzer;
    logic              r_beep;
    logic              r_snoozing;
    logic [c_cw-1:0]   r_ring_cnt;
    logic [c_cw-1:0]   r_wait_cnt;
    logic [c_cw-1:0]   r_snooze_cnt;

    logic [2:0] w_btn;
    logic       w_pause_evt;
    logic       w_snooze_evt;
    logic       w_modo_evt;
    logic [2:0] w_match;
    logic [2:0] w_active_oh;
    logic [2:0] w_match_eff;
    logic [2:0] w_cand;
    logic [2:0] w_take;
    logic [1:0] w_take_id;
    logic       w_kill;
    logic [1:0] w_disp_next;
    logic [3:0] w_sel_disp;
    logic       w_dismiss;

    assign w_btn        = {botao_modo, botao_snooze, botao_pause};
    assign w_pause_evt  = r_btn_evt[0];
    assign w_snooze_evt = r_btn_evt[1];
    assign w_modo_evt   = r_btn_evt[2];

    assign w_match[0] = tick_1hz & alarme_en[0] & (horario_relogio == horario_alarme_1);
    assign w_match[1] = tick_1hz & alarme_en[1] & (horario_relogio == horario_alarme_2);
    assign w_match[2] = tick_1hz & alarme_en[2] & (horario_relogio == horario_alarme_3);

    // A re-hit of the alarm currently in service is dropped, not queued.
    assign w_active_oh = {r_active == 2'd3, r_active == 2'd2, r_active == 2'd1};
    assign w_match_eff = w_match & ~w_active_oh;
    assign w_cand      = (r_pending | w_match_eff) & alarme_en;
    assign w_take      = w_cand & (~w_cand + 3'd1);
    assign w_take_id   = {w_take[2] | w_take[1], w_take[2] | w_take[0]};
    assign w_kill      = |(w_active_oh & ~alarme_en);

    assign w_disp_next = (w_modo_evt && (r_state != S_RINGING)) ? r_disp + 2'd1 : r_disp;
    assign w_sel_disp  = c_sel_clock << w_disp_next;

    assign w_dismiss = ((r_state == S_RINGING) &&
                        (w_kill || w_pause_evt ||
                         (tick_1hz && (r_ring_cnt == c_ring_last)) ||
                         (w_snooze_evt && (r_snooze_cnt >= c_snooze_max)))) ||
                       ((r_state == S_SNOOZE) && (w_kill || w_pause_evt));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_btn_q      <= 3'b000;
            r_btn_evt    <= 3'b000;
            r_pending    <= 3'b000;
            r_disp       <= 2'd0;
            r_sel        <= c_sel_clock;
            r_active     <= 2'd0;
            r_buzzer     <= 1'b0;
            r_beep       <= 1'b0;
            r_snoozing   <= 1'b0;
            r_ring_cnt   <= '0;
            r_wait_cnt   <= '0;
            r_snooze_cnt <= '0;
        end else begin
            r_btn_q   <= w_btn;
            r_btn_evt <= w_btn & ~r_btn_q;
            r_disp    <= w_disp_next;
            r_pending <= w_cand & ~((r_state == S_IDLE) ? w_take : 3'b000);

            if (w_dismiss) begin
                // Next pending alarm is picked up from IDLE one cycle later.
                r_state    <= S_IDLE;
                r_active   <= 2'd0;
                r_buzzer   <= 1'b0;
                r_beep     <= 1'b0;
                r_snoozing <= 1'b0;
                r_sel      <= w_sel_disp;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (|w_cand) begin
                            r_state      <= S_RINGING;
                            r_active     <= w_take_id;
                            r_ring_cnt   <= '0;
                            r_wait_cnt   <= '0;
                            r_snooze_cnt <= '0;
                            r_beep       <= 1'b1;
                            r_buzzer     <= 1'b1;
                            r_snoozing   <= 1'b0;
                            r_sel        <= c_sel_clock;
                        end else begin
                            r_sel <= w_sel_disp;
                        end
                    end
                    S_RINGING: begin
                        if (w_snooze_evt) begin
                            r_state      <= S_SNOOZE;
                            r_snooze_cnt <= (r_snooze_cnt == '1) ? r_snooze_cnt : r_snooze_cnt + c_one;
                            r_wait_cnt   <= '0;
                            r_buzzer     <= 1'b0;
                            r_snoozing   <= 1'b1;
                            r_sel        <= w_sel_disp;
                        end else if (tick_1hz) begin
                            r_beep     <= ~r_beep;
                            r_buzzer   <= ~r_beep;
                            r_ring_cnt <= (r_ring_cnt == '1) ? r_ring_cnt : r_ring_cnt + c_one;
                        end
                    end
                    S_SNOOZE: begin
                        if (tick_1hz && (r_wait_cnt == c_snooze_last)) begin
                            r_state    <= S_RINGING;
                            r_ring_cnt <= '0;
                            r_beep     <= 1'b1;
                            r_buzzer   <= 1'b1;
                            r_snoozing <= 1'b0;
                            r_sel      <= c_sel_clock;
                        end else begin
                            r_sel <= w_sel_disp;
                            if (tick_1hz) begin
                                r_wait_cnt <= (r_wait_cnt == '1) ? r_wait_cnt : r_wait_cnt + c_one;
                            end
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign sel_relogio  = r_sel[0];
    assign sel_alarme1  = r_sel[1];
    assign sel_alarme2  = r_sel[2];
    assign sel_alarme3  = r_sel[3];
    assign buzzer       = r_buzzer;
    assign alarme_ativo = r_active;
    assign snoozing     = r_snoozing;

endmodule
`default_nettype wire
